// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared datapath types and defaults for the subtract pipeline
package alu_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int HALF_DEFAULT  = WIDTH_DEFAULT / 2;

    typedef struct packed {
        logic [HALF_DEFAULT-1:0] lo_diff;
        logic                    lo_carry;
        logic [HALF_DEFAULT-1:0] a_hi;
        logic [HALF_DEFAULT-1:0] b_hi;
    } s1_payload_t;

    typedef struct packed {
        logic b_out;
        logic ovf;
        logic zero;
    } sub_flags_t;

endpackage

// File: rtl/sub_half.sv
// rtl/sub_half.sv - combinational H-bit x + ~y + c_in slice from 4-bit CLA groups
module sub_half #(
    parameter int H = 8
) (
    input  logic [H-1:0] x,
    input  logic [H-1:0] y,
    input  logic         c_in,
    output logic [H-1:0] d,
    output logic         c_out
);

    localparam int NG = H / 4;

    logic [H-1:0] g;
    logic [H-1:0] p;
    logic [H:0]   c;

    assign g    = x & ~y;
    assign p    = x ^ ~y;
    assign c[0] = c_in;

    // Full lookahead inside each group, group carries ripple between groups.
    for (genvar k = 0; k < NG; k++) begin : g_cla
        localparam int I = 4 * k;
        assign c[I+1] = g[I] | (p[I] & c[I]);
        assign c[I+2] = g[I+1] | (p[I+1] & g[I]) | (p[I+1] & p[I] & c[I]);
        assign c[I+3] = g[I+2] | (p[I+2] & g[I+1]) | (p[I+2] & p[I+1] & g[I])
                      | (p[I+2] & p[I+1] & p[I] & c[I]);
        assign c[I+4] = g[I+3] | (p[I+3] & g[I+2]) | (p[I+3] & p[I+2] & g[I+1])
                      | (p[I+3] & p[I+2] & p[I+1] & g[I])
                      | (p[I+3] & p[I+2] & p[I+1] & p[I] & c[I]);
    end

    assign d     = p ^ c[H-1:0];
    assign c_out = c[H];

endmodule

// File: rtl/sub_pipe16.sv
// rtl/sub_pipe16.sv - two-stage valid/ready pipelined subtractor with borrow and flags
module sub_pipe16
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             zero
);

    localparam int H = WIDTH / 2;

    logic         s1_valid;
    logic         s2_valid;
    logic [H-1:0] lo_diff;
    logic         lo_carry;
    logic [H-1:0] a_hi;
    logic [H-1:0] b_hi;

    logic [H-1:0] lo_d_next;
    logic         lo_c_next;
    logic [H-1:0] hi_d_next;
    logic         hi_c_next;

    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_next;
    sub_flags_t       flags_q;
    sub_flags_t       flags_next;

    logic s1_load;
    logic s2_load;

    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);

    // Subtraction is a + ~b + 1 with the borrow-in folded into the carry-in.
    sub_half #(.H(H)) u_lo (
        .x     (a[H-1:0]),
        .y     (b[H-1:0]),
        .c_in  (~b_in),
        .d     (lo_d_next),
        .c_out (lo_c_next)
    );

    sub_half #(.H(H)) u_hi (
        .x     (a_hi),
        .y     (b_hi),
        .c_in  (lo_carry),
        .d     (hi_d_next),
        .c_out (hi_c_next)
    );

    always_comb begin
        diff_next        = {hi_d_next, lo_diff};
        flags_next.b_out = ~hi_c_next;
        flags_next.ovf   = (a_hi[H-1] != b_hi[H-1]) && (hi_d_next[H-1] != a_hi[H-1]);
        flags_next.zero  = (diff_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            lo_diff  <= '0;
            lo_carry <= 1'b0;
            a_hi     <= '0;
            b_hi     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                lo_diff  <= lo_d_next;
                lo_carry <= lo_c_next;
                a_hi     <= a[WIDTH-1:H];
                b_hi     <= b[WIDTH-1:H];
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff_q   <= '0;
            flags_q  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                diff_q   <= diff_next;
                flags_q  <= flags_next;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;
    assign diff      = diff_q;
    assign b_out     = flags_q.b_out;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

endmodule
